// File: rtl/sys_issue_arbiter.sv
// Issue arbiter for the system unit: picks the oldest valid entry among
// the GPR, SPR and CR reservation stations (age measured from the oldest
// in-flight ID, wrap-aware) and holds it in a single output register with
// a valid/ready handshake. Also counts backpressure cycles, saturating.
module sys_issue_arbiter #(
  parameter int RS_ID_WIDTH = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             req_valid,
  output logic [2:0]             req_ready,
  input  logic [RS_ID_WIDTH-1:0] req_rs_id   [3],
  input  logic [DATA_WIDTH-1:0]  req_op      [3],
  input  logic [CTRL_WIDTH-1:0]  req_control [3],
  input  logic [RS_ID_WIDTH-1:0] head_rs_id,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RS_ID_WIDTH-1:0] out_rs_id,
  output logic [DATA_WIDTH-1:0]  out_op,
  output logic [CTRL_WIDTH-1:0]  out_control,
  output logic [1:0]             out_src,
  output logic [15:0]            stall_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [RS_ID_WIDTH-1:0] rs_id_q;
  logic [DATA_WIDTH-1:0]  op_q;
  logic [CTRL_WIDTH-1:0]  ctrl_q;
  logic [1:0]             src_q;
  logic [15:0]            stall_q;

  logic [RS_ID_WIDTH-1:0] age_s [3];
  logic [RS_ID_WIDTH-1:0] best_age_s;
  logic                   found_s;
  logic [1:0]             sel_idx_s;
  logic [RS_ID_WIDTH-1:0] sel_id_s;
  logic [DATA_WIDTH-1:0]  sel_op_s;
  logic [CTRL_WIDTH-1:0]  sel_ctrl_s;
  logic                   load_s;
  logic                   full_s;

  assign full_s = (state_q == ST_FULL);

  // Age of each offered entry relative to the head; the modular subtraction
  // makes IDs that wrapped past zero still compare as younger than the head.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      age_s[i] = req_rs_id[i] - head_rs_id;
    end
  end

  // Oldest-first selection; strict less-than keeps the lowest index on ties.
  always_comb begin
    found_s    = 1'b0;
    best_age_s = '0;
    sel_idx_s  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && (!found_s || (age_s[i] < best_age_s))) begin
        found_s    = 1'b1;
        best_age_s = age_s[i];
        sel_idx_s  = 2'(i);
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Payload multiplexer for the selected requester.
  always_comb begin
    case (sel_idx_s)
      2'd1: begin
        sel_id_s   = req_rs_id[1];
        sel_op_s   = req_op[1];
        sel_ctrl_s = req_control[1];
      end
      2'd2: begin
        sel_id_s   = req_rs_id[2];
        sel_op_s   = req_op[2];
        sel_ctrl_s = req_control[2];
      end
      default: begin
        sel_id_s   = req_rs_id[0];
        sel_op_s   = req_op[0];
        sel_ctrl_s = req_control[0];
      end
    endcase
  end

  // A new entry is taken when the register is free or draining, something is
  // offered, no flush is pending, and the block is out of reset.
  assign load_s = rst & ~flush & found_s & (~full_s | out_ready);

  // Grant goes only to the selected requester, and only on a load.
  assign req_ready = {load_s & (sel_idx_s == 2'd2),
                      load_s & (sel_idx_s == 2'd1),
                      load_s & (sel_idx_s == 2'd0)};

  // Next state: flush wins, then load, then drain, else hold.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (load_s) begin
      state_d = ST_FULL;
    end else begin
      case (state_q)
        ST_FULL:  state_d = out_ready ? ST_EMPTY : ST_FULL;
        ST_EMPTY: state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Output register, state and stall counter; reset abandons any held entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      rs_id_q <= '0;
      op_q    <= '0;
      ctrl_q  <= '0;
      src_q   <= 2'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (load_s) begin
        rs_id_q <= sel_id_s;
        op_q    <= sel_op_s;
        ctrl_q  <= sel_ctrl_s;
        src_q   <= sel_idx_s;
      end else begin
        rs_id_q <= rs_id_q;
        op_q    <= op_q;
        ctrl_q  <= ctrl_q;
        src_q   <= src_q;
      end
      if (full_s && !out_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end else begin
        stall_q <= stall_q;
      end
    end
  end

  assign out_valid   = full_s;
  assign out_rs_id   = rs_id_q;
  assign out_op      = op_q;
  assign out_control = ctrl_q;
  assign out_src     = src_q;
  assign stall_count = stall_q;

endmodule
